seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider, the successor to the combinational 16-bit unsigned divider.
//  Adds a signed mode, a start/busy/done handshake, divide-by-zero and overflow flags, and a one-bit-per-cycle datapath.
//  Sits in ArithmeticUnit beside the other ALU arithmetic blocks; the ALU result mux reads outputs held after done.
// PARAMETERS
//  WIDTH    16  operand/result width in bits, >= 4
//  CNT_W    $clog2(WIDTH+1)  iteration counter width (localparam, derived)
// PORTS
//  clk          in   1      single clock; all flops are rising-edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      request a division; accepted only when busy==0
//  signed_mode  in   1      1: two's-complement operands; 0: unsigned; sampled with start
//  dividend     in   WIDTH  sampled on the accepting edge
//  divisor      in   WIDTH  sampled on the accepting edge
//  busy         out  1      high from the accepting edge until done is asserted
//  done         out  1      one-cycle pulse: results valid
//  quotient     out  WIDTH  held from done until the next done
//  remainder    out  WIDTH  held from done until the next done
//  div_by_zero  out  1      held with results; divisor was 0
//  overflow     out  1      held with results; signed MIN / -1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, flags=0. Reset mid-operation aborts with no done.
//  States: IDLE -> CALC -> FIX -> IDLE; IDLE -> FIX directly for special cases.
//  IDLE:
//   - start=1 at edge E0: latch mode, sign bits, |dividend| and |divisor| (magnitudes in WIDTH+1 bits), clear partial remainder, cnt=WIDTH, busy=1.
//   - divisor==0 or (signed_mode && dividend==MIN && divisor=={WIDTH{1'b1}}): go straight to FIX (special path).
//  CALC: one restoring step per edge.
//   - Shift {rem,quo} left 1; trial = rem - |divisor|; if trial >= 0 then rem=trial and quo[0]=1.
//   - cnt decrements; leave CALC when cnt reaches 1 at the edge.
//  FIX: write outputs, pulse done, clear busy, return to IDLE.
//   - Normal: unsigned results as computed; signed: quotient negated if sign(dividend)!=sign(divisor); remainder takes the sign of dividend (truncation toward zero).
//   - Divide by zero: quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1, overflow=0 (either mode).
//   - Signed overflow: quotient=MIN (dividend), remainder=0, overflow=1.
//  Latency (start edge E0 to the edge that raises done):
//   - Normal: WIDTH+1 edges, i.e. done is high in the cycle after edge E0+WIDTH+1.
//   - Special path: 1 edge (done after E0+1).
//  Handshake:
//   - start while busy=1 is ignored with no queuing.
//   - start in the same cycle as done is accepted (back-to-back allowed, throughput WIDTH+2 cycles).
//   - done is never high two consecutive cycles.
//  Flags and results change only on the done edge; every new done overwrites all four of them.
//  Operand inputs may change freely after the accepting edge.
// STRUCTURE
//  Package div_pkg:
//   - state enum {IDLE, CALC, FIX}
//   - QUO_DIV0 pattern for the all-ones divide-by-zero quotient
//   - function abs_val(value, signed_mode)
//  One sub-module div_step:
//   - combinational single restoring iteration, WIDTH-parametrised
//   - inputs: rem, quo, divisor magnitude; outputs: next rem, next quo
//   - instantiated once in CALC
//  Top level holds the FSM, counter, sign bookkeeping and output registers.
// TESTING
//  1 unsigned 100/10 -> q=10, r=0, done at E0+17, flags 0; 103/10 -> q=10, r=3.
//  2 unsigned 50/0 -> q=16'hFFFF, r=50, div_by_zero=1, done one edge after start; 16'hFFFF/2 -> q=16'h7FFF, r=1.
//  3 signed -7/2 -> q=16'hFFFD (-3), r=16'hFFFF (-1); 7/-2 -> q=-3, r=1; 16'h8000/16'hFFFF -> q=16'h8000, r=0, overflow=1.
//  4 start pulsed while busy with 5/1 -> ignored; original 12345/1 completes with q=12345, r=0.
//  5 start asserted in the done cycle -> second op 4321/4321 accepted, q=1 r=0 after a further WIDTH+1 edges.
//  6 rst_n low at cycle 8 of an op -> busy=0, outputs 0, no done pulse; next op 0/12345 -> q=0, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the sequential divider.
//   state_t   - divider control states
//   ABS_W     - widest operand the magnitude helper handles
//   QUO_DIV0  - all-ones quotient pattern returned on divide-by-zero
//   abs_val   - two's-complement magnitude; the caller pre-extends the operand
//               to ABS_W bits and casts the result back to its own width
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int ABS_W = 64;

   localparam logic [ABS_W-1:0] QUO_DIV0 = {ABS_W{1'b1}};

   // Magnitude of a sign- or zero-extended operand; negation only in signed mode
   function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] value,
                                               input logic             signed_mode);
      logic [ABS_W-1:0] mag;
      if (signed_mode && value[ABS_W-1]) begin
         mag = -value;
      end else begin
         mag = value;
      end
      return mag;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem      in  WIDTH    partial remainder (always < divisor magnitude)
//   quo      in  WIDTH    dividend bits still to shift in / quotient so far
//   dvs      in  WIDTH+1  divisor magnitude
//   rem_next out WIDTH    partial remainder after this step
//   quo_next out WIDTH    quotient/dividend register after this step
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic           fits;

   // Shift {rem,quo} left one bit and try to subtract the divisor
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      fits   = (rem_sh >= dvs);
      if (fits) begin
         // The difference is below the divisor, so it fits back into WIDTH bits
         rem_next = WIDTH'(rem_sh - dvs);
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned, one
// quotient bit per clock, start/busy/done handshake.
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start               request; accepted only in IDLE (busy low)
//   signed_mode         two's-complement operands when 1, sampled with start
//   dividend, divisor   operands, sampled on the accepting edge
//   busy                high from accepting edge until done
//   done                one-cycle result-valid pulse
//   quotient, remainder results, held until the next done
//   div_by_zero         divisor was zero (held with results)
//   overflow            signed MIN / -1 (held with results)
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo;
   logic [WIDTH:0]   dvs_mag;
   logic             dvd_neg, dvs_neg, is_div0, is_ovf;

   logic [WIDTH-1:0] step_rem, step_quo;
   logic             in_dvd_neg, in_dvs_neg, in_div0, in_ovf;
   logic [WIDTH-1:0] in_dvd_mag;
   logic [WIDTH:0]   in_dvs_mag;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs_mag),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Operand decode: sign bits, magnitudes and special-case detection
   always_comb begin
      in_dvd_neg = signed_mode & dividend[WIDTH-1];
      in_dvs_neg = signed_mode & divisor[WIDTH-1];
      in_dvd_mag = WIDTH'(abs_val({{(ABS_W-WIDTH){in_dvd_neg}}, dividend}, signed_mode));
      in_dvs_mag = (WIDTH+1)'(abs_val({{(ABS_W-WIDTH){in_dvs_neg}}, divisor}, signed_mode));
      in_div0    = (divisor == ZERO);
      in_ovf     = signed_mode & (dividend == MIN_VAL) & (divisor == ALL_ONES);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; special cases skip the iterations entirely
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (in_div0 || in_ovf) begin
                  state_next = FIX;
               end else begin
                  state_next = CALC;
               end
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            if (cnt == CNT_W'(1)) begin
               state_next = FIX;
            end else begin
               state_next = CALC;
            end
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath, bookkeeping and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= {CNT_W{1'b0}};
         rem         <= ZERO;
         quo         <= ZERO;
         dvs_mag     <= {(WIDTH+1){1'b0}};
         dvd_neg     <= 1'b0;
         dvs_neg     <= 1'b0;
         is_div0     <= 1'b0;
         is_ovf      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= ZERO;
         remainder   <= ZERO;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  dvd_neg <= in_dvd_neg;
                  dvs_neg <= in_dvs_neg;
                  rem     <= ZERO;
                  quo     <= in_dvd_mag;
                  dvs_mag <= in_dvs_mag;
                  cnt     <= CNT_W'(WIDTH);
                  is_div0 <= in_div0;
                  is_ovf  <= in_ovf & ~in_div0;
               end
            end
            CALC: begin
               rem <= step_rem;
               quo <= step_quo;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (is_div0) begin
                  // quo still holds |dividend|; re-sign it to return the raw dividend
                  quotient    <= WIDTH'(QUO_DIV0);
                  remainder   <= dvd_neg ? -quo : quo;
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (is_ovf) begin
                  quotient    <= MIN_VAL;
                  remainder   <= ZERO;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b1;
               end else begin
                  // Truncating division: remainder follows the dividend's sign
                  quotient    <= (dvd_neg ^ dvs_neg) ? -quo : quo;
                  remainder   <= dvd_neg ? -rem : rem;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
